// File: rtl/instr_executor.sv
// Walks read_pointer over a contiguous window of the instruction register stack,
// executes each {opc,op_a,op_b} word and hands results out over valid/ready.
module instr_executor #(
  parameter int OP_W   = 32,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           count,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         read_pointer,
  input  logic [OPC_W+2*OP_W-1:0]   instruction_word,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*OP_W-1:0]         res_data,
  output logic [ADDR_W-1:0]         res_addr,
  output logic [OPC_W-1:0]          res_opc,
  output logic                      res_err,
  output logic [2:0]                dbg_state_o
);

  localparam int RW = 2 * OP_W;
  localparam int IW = OPC_W + 2 * OP_W;

  localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic [IW-1:0]       iw_q, iw_d;
  logic                res_valid_q, res_valid_d;
  logic [RW-1:0]       res_data_q, res_data_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic [OPC_W-1:0]    res_opc_q, res_opc_d;
  logic                res_err_q, res_err_d;

  logic [OPC_W-1:0]    opc;
  logic signed [RW-1:0] a_ext, b_ext, alu_res;
  logic                alu_err;

  assign opc   = iw_q[IW-1 -: OPC_W];
  assign a_ext = {{OP_W{iw_q[2*OP_W-1]}}, iw_q[2*OP_W-1:OP_W]};
  assign b_ext = {{OP_W{iw_q[OP_W-1]}}, iw_q[OP_W-1:0]};

  // Signed '/' and '%' give truncation toward zero and a remainder that follows op_a.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opc)
      OPC_ZERO:  alu_res = '0;
      OPC_PASSA: alu_res = a_ext;
      OPC_PASSB: alu_res = b_ext;
      OPC_ADD:   alu_res = a_ext + b_ext;
      OPC_SUB:   alu_res = a_ext - b_ext;
      OPC_MULT:  alu_res = a_ext * b_ext;
      OPC_DIV: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext % b_ext;
      end
      default:   alu_err = 1'b1;
    endcase
  end

  // Result handshake: res_valid rises out of EXEC and, together with every res_*
  // field, holds until an edge where res_ready is also high; that edge is the transfer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rp_d        = rp_q;
    iw_d        = iw_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    res_opc_d   = res_opc_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_d  = base_addr;
            rem_d   = count;
            rp_d    = base_addr;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        iw_d    = instruction_word;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_res;
        res_err_d   = alu_err;
        res_addr_d  = addr_q;
        res_opc_d   = opc;
        addr_d      = addr_q + ADDR_W'(1);
        rem_d       = rem_q - (ADDR_W + 1)'(1);
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (rem_q != '0) begin
            rp_d    = addr_q;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rp_q        <= '0;
      iw_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      res_opc_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rp_q        <= rp_d;
      iw_q        <= iw_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      res_opc_q   <= res_opc_d;
      res_err_q   <= res_err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign read_pointer = rp_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_addr     = res_addr_q;
  assign res_opc      = res_opc_q;
  assign res_err      = res_err_q;
  assign dbg_state_o  = state_q;

endmodule
